baudrate_generator: RTL and testbench

BAUDRATE_GENERATOR -- requirements
Module: baudrate_generator

---
 rtl/baudrate_pkg.sv | 11 +
 rtl/baudrate_generator.sv | 38 +++
 tb/tb_baudrate_generator.sv | 111 +++++++++++
 3 files changed

// File: rtl/baudrate_pkg.sv
// baudrate_pkg: default counter settings and a width helper for the baud rate tick generator
package baudrate_pkg;
    localparam int DEF_MAX_COUNT = 163;
    localparam int DEF_NUM_BITS  = 8;
    function automatic int baud_width(input int max_count);
        int w;
        w = 1;
        while ((1 << w) <= max_count) w++;
        return w;
    endfunction
endpackage

// File: rtl/baudrate_generator.sv
// baudrate_generator: free-running wrap counter with a one-cycle tick at terminal count
// o_count is compiled in only when BAUDRATE_GEN_COUNT_OUT_EN is defined.
module baudrate_generator
    import baudrate_pkg::*;
#(
    parameter int BAUDRATE_MAX_COUNT = DEF_MAX_COUNT,
    parameter int BAUDRATE_NUM_BITS  = DEF_NUM_BITS
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
`ifdef BAUDRATE_GEN_COUNT_OUT_EN
    output logic [BAUDRATE_NUM_BITS-1:0] o_count,
`else
`endif
    output logic                         o_tick
);
    if (BAUDRATE_NUM_BITS < 1 || BAUDRATE_MAX_COUNT < 0 ||
        (BAUDRATE_NUM_BITS < 31 && BAUDRATE_MAX_COUNT >= (1 << BAUDRATE_NUM_BITS))) begin : g_bad_params
        $fatal(1, "baudrate_generator: BAUDRATE_MAX_COUNT does not fit in BAUDRATE_NUM_BITS");
    end
    localparam logic [BAUDRATE_NUM_BITS-1:0] MAX_C = BAUDRATE_NUM_BITS'(BAUDRATE_MAX_COUNT);
    logic [BAUDRATE_NUM_BITS-1:0] cnt_q, cnt_d;
    logic                         rst_q, rst_d;
    always_comb begin
        cnt_d = i_reset ? '0 : (cnt_q == MAX_C) ? '0 : cnt_q + 1'b1;
        rst_d = i_reset;
    end
    always_ff @(posedge i_clk) begin
        cnt_q <= cnt_d;
        rst_q <= rst_d;
    end
    // the reset flag only matters for MAX_COUNT=0, where count 0 is also terminal
    assign o_tick = (cnt_q == MAX_C) && !rst_q;
`ifdef BAUDRATE_GEN_COUNT_OUT_EN
    assign o_count = cnt_q;
`else
`endif
endmodule

// File: tb/tb_baudrate_generator.sv
// tb_baudrate_generator: directed checks of tick timing, reset override and the MAX_COUNT=0 case
module tb_baudrate_generator;
    import baudrate_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick, tickz;
`ifdef BAUDRATE_GEN_COUNT_OUT_EN
    logic [4:0] cnt;
    logic [0:0] cntz;
`endif
    int total = 0;
    int bad = 0;
    typedef struct {
        logic       rst;
        logic       tick;
        logic       tickz;
        logic [4:0] cnt;
    } vec_t;
    vec_t tv[40];

    always #5 clk = ~clk;

    baudrate_generator #(.BAUDRATE_MAX_COUNT(15), .BAUDRATE_NUM_BITS(5)) dut (
        .i_clk(clk),
        .i_reset(rst),
`ifdef BAUDRATE_GEN_COUNT_OUT_EN
        .o_count(cnt),
`endif
        .o_tick(tick)
    );

    baudrate_generator #(.BAUDRATE_MAX_COUNT(0), .BAUDRATE_NUM_BITS(1)) dutz (
        .i_clk(clk),
        .i_reset(rst),
`ifdef BAUDRATE_GEN_COUNT_OUT_EN
        .o_count(cntz),
`endif
        .o_tick(tickz)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic r);
        rst = r;
        @(negedge clk);
    endtask

    task automatic chk_state(input string name, input logic t, input logic tz, input logic [4:0] c);
        chk({name, "_tick"}, {31'b0, tick}, {31'b0, t});
        chk({name, "_tickz"}, {31'b0, tickz}, {31'b0, tz});
`ifdef BAUDRATE_GEN_COUNT_OUT_EN
        chk({name, "_count"}, {27'b0, cnt}, {27'b0, c});
        chk({name, "_countz"}, {31'b0, cntz}, 32'd0);
`endif
    endtask

    initial begin
        int lows;
        longint first_t;
        first_t = 0;
        for (int i = 0; i < 40; i++) begin
            tv[i].rst   = (i == 0);
            tv[i].cnt   = 5'(i % 16);
            tv[i].tick  = (i % 16 == 15);
            tv[i].tickz = (i != 0);
        end
        chk("width_15", baud_width(15), 4);
        chk("width_16", baud_width(16), 5);
        chk("width_163", baud_width(163), 8);
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            cyc(tv[i].rst);
            if (tick === 1'b1 && first_t == 0) first_t = $time;
            chk_state($sformatf("vec%0d", i), tv[i].tick, tv[i].tickz, tv[i].cnt);
        end
        chk("first_tick_time", 32'(first_t), 32'd170);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1);
            chk_state("mid_reset", 1'b0, 1'b0, 5'd0);
        end
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b0);
            chk_state($sformatf("after_mid_reset%0d", k), k == 15, 1'b1, 5'(k % 16));
        end
        for (int k = 1; k <= 15; k++) cyc(1'b0);
        chk_state("at_tick", 1'b1, 1'b1, 5'd15);
        cyc(1'b1);
        chk_state("reset_on_tick", 1'b0, 1'b0, 5'd0);
        for (int k = 1; k <= 15; k++) begin
            cyc(1'b0);
            chk_state($sformatf("after_tick_reset%0d", k), k == 15, 1'b1, 5'(k));
        end
        for (int p = 0; p < 4; p++) begin
            lows = 0;
            cyc(1'b0);
            while (tick !== 1'b1 && lows < 40) begin
                lows++;
                cyc(1'b0);
            end
            chk($sformatf("period_lows%0d", p), lows, 15);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
